// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants, error bit indices and FSM states for the video frame sink
package video_pkg;

  // default image geometry and pixel width
  localparam int VID_W  = 32;
  localparam int VID_H  = 32;
  localparam int VID_AW = 10;
  localparam int VID_DW = 8;

  // bit positions inside the sticky per-frame error word
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_LINES = 2;
  localparam int ERR_COORD = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    LINE      = 2'd2
  } state_t;

endpackage

// File: rtl/video_frame_sink_edge_det.sv
// rtl/video_frame_sink_edge_det.sv - registered rise/fall detector for a level framing signal
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // one-cycle history of the input; the reset value decides whether a level
  // already high at reset release counts as a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= RST_VAL;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/video_frame_sink.sv
// rtl/video_frame_sink.sv - framing checker and frame-buffer writer for the data_gen pixel stream
module video_frame_sink
  import video_pkg::*;
#(
  parameter int W  = VID_W,
  parameter int H  = VID_H,
  parameter int AW = VID_AW,
  parameter int DW = VID_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fs,
  input  logic          hs,
  input  logic [DW-1:0] data,
  input  logic [10:0]   hang_cnt_out,
  input  logic [10:0]   lie_cnt_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [3:0]    err,
  output logic [31:0]   pix_sum,
  output logic [15:0]   frame_cnt
);

  localparam logic [10:0]   W_C = 11'(W);
  localparam logic [10:0]   H_C = 11'(H);
  localparam logic [AW-1:0] W_A = AW'(W);

  logic fs_rise, fs_fall, hs_fall, hs_rise_unused;

  state_t        state, state_n;
  logic [10:0]   row, row_n, col, col_n;
  logic [31:0]   sum, sum_n;
  logic [AW-1:0] addr, addr_n;   // next write address, realigned to line_base at each line close
  logic [AW-1:0] base, base_n;   // row*W, advanced by W per closed line
  logic          open_frame, accept, close_line, end_frame;

  logic          wr_en_n, done_n, ok_n;
  logic [AW-1:0] wr_addr_n;
  logic [DW-1:0] wr_data_n;
  logic [3:0]    err_n;
  logic [31:0]   psum_n;
  logic [15:0]   fcnt_n;

  // fs history resets high so a frame already running at reset release is
  // ignored until fs drops and rises again
  edge_det #(.RST_VAL(1'b1)) u_fs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (fs),
    .rise (fs_rise),
    .fall (fs_fall)
  );

  edge_det #(.RST_VAL(1'b0)) u_hs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (hs),
    .rise (hs_rise_unused),
    .fall (hs_fall)
  );

  // next-state: frame open, pixel accept, line close and frame end, applied in
  // that order so a frame that opens with hs already high takes its first pixel
  always_comb begin
    state_n    = state;
    row_n      = row;
    col_n      = col;
    sum_n      = sum;
    addr_n     = addr;
    base_n     = base;
    err_n      = err;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    done_n     = 1'b0;
    ok_n       = frame_ok;
    psum_n     = pix_sum;
    fcnt_n     = frame_cnt;
    open_frame = 1'b0;
    accept     = 1'b0;
    close_line = 1'b0;
    end_frame  = 1'b0;

    if (state == IDLE && fs_rise) begin
      open_frame = 1'b1;
      state_n    = WAIT_LINE;
      row_n      = '0;
      col_n      = '0;
      sum_n      = '0;
      addr_n     = '0;
      base_n     = '0;
      err_n      = '0;
    end

    accept     = (open_frame || state != IDLE) && fs && hs;
    close_line = (state == LINE) && (hs_fall || fs_fall);
    end_frame  = (state != IDLE) && fs_fall;

    if (accept) begin
      state_n = LINE;
      // lines beyond the frame height are only counted, never stored or checked
      if (row_n < H_C) begin
        if (hang_cnt_out != row_n || lie_cnt_out != col_n) err_n[ERR_COORD] = 1'b1;
        if (col_n < W_C) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_n;
          wr_data_n = data;
          addr_n    = addr_n + AW'(1);
          sum_n     = sum_n + 32'(data);
        end
      end
      if (col_n >= W_C) err_n[ERR_LONG] = 1'b1;
      // col keeps counting past W so coordinates stay comparable with the sender
      if (col_n != '1) col_n = col_n + 11'd1;
    end

    if (close_line) begin
      if (col_n < W_C)  err_n[ERR_SHORT] = 1'b1;
      if (row_n >= H_C) err_n[ERR_LINES] = 1'b1;
      if (row_n != '1)  row_n = row_n + 11'd1;
      col_n   = '0;
      base_n  = base_n + W_A;
      addr_n  = base_n;
      state_n = WAIT_LINE;
    end

    if (end_frame) begin
      if (row_n != H_C) err_n[ERR_LINES] = 1'b1;
      state_n = IDLE;
      done_n  = 1'b1;
      ok_n    = (err_n == 4'd0);
      psum_n  = sum_n;
      fcnt_n  = frame_cnt + 16'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // per-frame position, address and checksum accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      sum  <= '0;
      addr <= '0;
      base <= '0;
    end else begin
      row  <= row_n;
      col  <= col_n;
      sum  <= sum_n;
      addr <= addr_n;
      base <= base_n;
    end
  end

  // registered outputs: writes and frame status appear one cycle after the event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err        <= '0;
      pix_sum    <= '0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= done_n;
      frame_ok   <= ok_n;
      err        <= err_n;
      pix_sum    <= psum_n;
      frame_cnt  <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_video_frame_sink.sv
// tb/tb_video_frame_sink.sv - randomized self-checking bench for video_frame_sink
module tb_video_frame_sink;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs = 1'b0;
  logic          hs = 1'b0;
  logic [DW-1:0] data = '0;
  logic [10:0]   hang = '0;
  logic [10:0]   lie = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          frame_ok;
  logic [3:0]    err;
  logic [31:0]   pix_sum;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  video_frame_sink #(.W(W), .H(H), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fs          (fs),
    .hs          (hs),
    .data        (data),
    .hang_cnt_out(hang),
    .lie_cnt_out (lie),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .err         (err),
    .pix_sum     (pix_sum),
    .frame_cnt   (frame_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int          qa[$];
  int          qd[$];
  logic [3:0]  exp_err;
  logic [31:0] exp_sum;
  int          exp_writes;
  int          exp_fcnt = 0;
  logic [7:0]  mem [0:1023];

  // frame description
  int n_lines;
  int line_len[64];
  int fault_r, fault_c, abort_r, lead;
  bit pat_rc, tail_gap;
  logic [7:0] fault_px;

  // observed activity
  int          wr_seen = 0;
  int          done_cnt = 0;
  logic        cap_ok;
  logic [3:0]  cap_err;
  logic [31:0] cap_sum;
  logic [15:0] cap_cnt;

  // write and frame-done monitor
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_seen++;
      mem[wr_addr] = wr_data;
      if (qa.size() == 0) begin
        check("wr_extra", 32'(wr_en), 32'd0);
      end else begin
        check("wr_addr", 32'(wr_addr), 32'(qa.pop_front()));
        check("wr_data", 32'(wr_data), 32'(qd.pop_front()));
      end
    end
    if (rst_n && frame_done) begin
      done_cnt++;
      cap_ok  = frame_ok;
      cap_err = err;
      cap_sum = pix_sum;
      cap_cnt = frame_cnt;
    end
  end

  task automatic set_nominal();
    n_lines = H;
    for (int i = 0; i < 64; i++) line_len[i] = W;
    fault_r  = -1;
    fault_c  = -1;
    abort_r  = -1;
    pat_rc   = 1'b0;
    tail_gap = 1'b1;
    lead     = $urandom_range(3, 1);
  endtask

  task automatic do_reset();
    int d0, w0;
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ok", 32'(frame_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sum", pix_sum, 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    qa.delete();
    qd.delete();
    exp_fcnt = 0;
    hs = 1'b0;
    d0 = done_cnt;
    w0 = wr_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    fs = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_no_write", 32'(wr_seen - w0), 32'd0);
  endtask

  task automatic send_frame(input string name);
    int d0, w0;
    bit aborted;
    logic [7:0] px;
    aborted    = 1'b0;
    exp_err    = '0;
    exp_sum    = '0;
    exp_writes = 0;
    d0 = done_cnt;
    w0 = wr_seen;
    @(negedge clk);
    fs = 1'b1;
    hs = 1'b0;
    repeat (lead) @(negedge clk);
    for (int r = 0; r < n_lines; r++) begin
      for (int c = 0; c < line_len[r]; c++) begin
        if (r == abort_r && c == 5) begin
          do_reset();
          aborted = 1'b1;
          break;
        end
        px   = pat_rc ? 8'(r + c) : 8'($urandom);
        hs   = 1'b1;
        data = px;
        hang = 11'(r);
        lie  = 11'(c + ((r == fault_r && c == fault_c) ? 1 : 0));
        if (r < H) begin
          if (r == fault_r && c == fault_c) begin
            exp_err[3] = 1'b1;
            fault_px   = px;
          end
          if (c < W) begin
            qa.push_back(r * W + c);
            qd.push_back(px);
            exp_sum += 32'(px);
            exp_writes++;
          end
        end
        if (c >= W) exp_err[1] = 1'b1;
        @(negedge clk);
      end
      if (aborted) break;
      if (line_len[r] < W) exp_err[0] = 1'b1;
      if (r >= H) exp_err[2] = 1'b1;
      hs = 1'b0;
      if (!(r == n_lines - 1 && !tail_gap)) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    if (!aborted) begin
      if (n_lines != H) exp_err[2] = 1'b1;
      fs = 1'b0;
      exp_fcnt++;
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({name, "_err"}, 32'(cap_err), 32'(exp_err));
      check({name, "_ok"}, 32'(cap_ok), 32'(exp_err == 4'd0));
      check({name, "_sum"}, cap_sum, exp_sum);
      check({name, "_cnt"}, 32'(cap_cnt), 32'(exp_fcnt[15:0]));
      check({name, "_writes"}, 32'(wr_seen - w0), 32'(exp_writes));
      check({name, "_pending"}, 32'(qa.size()), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("init_wr_en", 32'(wr_en), 32'd0);
    check("init_done", 32'(frame_done), 32'd0);
    check("init_err", 32'(err), 32'd0);
    check("init_sum", pix_sum, 32'd0);
    check("init_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_nominal(); pat_rc = 1'b1; lead = 2;
    send_frame("nominal");
    check("nominal_sum_abs", cap_sum, 32'd31744);

    set_nominal(); line_len[5] = 30;
    send_frame("short5");

    set_nominal(); line_len[7] = 34;
    send_frame("long7");

    set_nominal(); n_lines = 31;
    send_frame("lines31");

    set_nominal(); n_lines = 33;
    send_frame("lines33");

    set_nominal(); fault_r = 2; fault_c = 10;
    mem[74] = 8'hxx;
    send_frame("coord");
    check("coord_addr74", 32'(mem[74]), 32'(fault_px));

    set_nominal(); lead = 0;
    send_frame("lead0");

    set_nominal(); tail_gap = 1'b0;
    send_frame("notail");

    set_nominal(); abort_r = 16;
    send_frame("abort");

    set_nominal();
    send_frame("post_reset");
    check("post_reset_cnt_abs", 32'(cap_cnt), 32'd1);

    set_nominal();
    send_frame("rand_clean");

    set_nominal();
    n_lines = $urandom_range(34, 30);
    for (int i = 0; i < 64; i++) line_len[i] = $urandom_range(34, 30);
    send_frame("rand_irregular");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_frame_sink.md
Name: video_frame_sink

Overview:
- Receiving end of the pixel-stream interface driven by data_gen (fs/hs/data/hang_cnt_out/lie_cnt_out).
- Checks the stream's framing against the configured image size and writes every accepted pixel into a frame buffer through a simple write port.
- Reports per-frame completion, error status and a pixel checksum, so connect_domain_get benches and the file_io flow can compare the streamed image against the source file.

Parameters:
- W, 32: active pixels per line.
- H, 32: active lines per frame.
- AW, 10: frame-buffer address width; W*H must fit in 2^AW.
- DW, 8: pixel width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fs  in  1  frame valid, level; high for the whole frame.
- hs  in  1  line valid, level; pixel present when fs&hs.
- data  in  DW  pixel value.
- hang_cnt_out  in  11  sender row index of the current pixel.
- lie_cnt_out  in  11  sender column index of the current pixel.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  AW  write address = row*W+col.
- wr_data  out  DW  write data.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_ok  out  1  valid with frame_done: err==0.
- err  out  4  sticky per-frame errors: [0] short line, [1] long line, [2] line-count mismatch, [3] coordinate mismatch.
- pix_sum  out  32  sum of accepted pixels of the last frame; updated at frame_done.
- frame_cnt  out  16  frames completed; wraps at 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal row/col/accumulator 0. Reset mid-frame abandons the frame with no frame_done. After release, wait for a fresh fs rising edge.
- Edge detection: fs and hs are registered one cycle to detect edges. Pixel accept = fs&hs in state LINE.
- IDLE -> WAIT_LINE on fs rising edge. This clears row, col, err and the accumulator.
- WAIT_LINE -> LINE on hs high while fs high. The first pixel of the line is accepted in that same cycle.
- LINE:
  - Each accepted pixel with col<W: wr_en=1 the next cycle with wr_addr=row*W+col, wr_data=data. col++, accumulator += data (32-bit wrap).
  - Write latency is exactly 1 cycle.
  - Pixels with col>=W are not written and not summed. They set err[1].
  - Any accepted pixel whose hang_cnt_out!=row or lie_cnt_out!=col (compared before increment) sets err[3]; the pixel is still written if col<W.
- LINE -> WAIT_LINE on hs falling edge:
  - If col<W, set err[0].
  - row++ and col=0.
  - If row was already >=H, the line was not written and err[2] is set.
- Lines with row>=H: pixels are not written, not summed, and the coordinate check is skipped.
- End of frame: fs falling edge in WAIT_LINE or LINE.
  - If in LINE, close the line first, with identical checks, in the same cycle.
  - If final row!=H, set err[2].
  - Next cycle: frame_done=1 for one cycle, frame_ok=(err==0), pix_sum latched, frame_cnt++. Return to IDLE.
- err holds its value until the next fs rising edge.
- fs high with hs high on the same first cycle: the frame opens and the pixel is accepted, i.e. IDLE acts as WAIT_LINE for that cycle.
- fs rising without a preceding fall cannot occur; a stuck-high fs never produces frame_done.
- Address arithmetic: row*W+col is computed in AW bits. Use an incrementing address register (reset per frame, +1 per written pixel), not a multiplier.

Decomposition:
- Shared package video_pkg holds:
  - default W/H/DW constants;
  - the err bit indices (ERR_SHORT=0, ERR_LONG=1, ERR_LINES=2, ERR_COORD=3);
  - the state enum (IDLE, WAIT_LINE, LINE).
- One sub-module: edge_det, a registered rise/fall detector instantiated for fs and hs.

Test Plan:
- Nominal 32x32 frame from data_gen with pixel=(row+col)&0xFF:
  - 1024 writes at addresses 0..1023 with matching data;
  - frame_done once, frame_ok=1, err=0, pix_sum=31744, frame_cnt=1.
- Line 5 truncated to 30 pixels: err[0]=1, frame_ok=0, and a total of 1022 writes.
- Line 7 of 34 pixels: err[1]=1; exactly 32 writes for row 7; extra pixels are not summed.
- Frame of 31 lines, and separately a frame of 33 lines: err[2]=1; the 33rd line produces no writes.
- lie_cnt_out forced off by one at row 2 col 10: err[3]=1; the pixel is still written at address 74.
- rst_n pulsed low mid-frame at row 16: outputs 0 immediately; no frame_done; the next full frame is clean, with frame_cnt=1.
